// File: rtl/riscv_pkg.sv
// Shared load/store encodings, LSU state type and the store-strobe helper.
// Pure declarations; no timing or flow control of its own.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Byte-lane enables for a store of the given size at byte offset off.
    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] strb;
        case (f3)
            F3_B:    strb = 4'b0001 << off;
            F3_H:    strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select plus sign/zero extension of a 32-bit read word; purely combinational.
// Zero latency, no flow control.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_BU:   o_result = {24'd0, w_byte};
            F3_HU:   o_result = {16'd0, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: issues one valid/ready bus request per load/store and stalls the core.
// Min 3 cycles (IDLE, REQ, DONE); REQ holds the bus until BusReady or TIMEOUT_CYCLES elapse.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Stall,
    output logic        MemFault,
    output logic        BusError,
    output logic        BusValid,
    output logic        BusWrite,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusWStrb,
    input  logic        BusReady,
    input  logic [31:0] BusRData
);

    lsu_state_t       r_state;
    lsu_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;

    logic        w_access;
    logic        w_ld_f3_ok;
    logic        w_st_f3_ok;
    logic        w_misalign;
    logic        w_fault_any;
    logic        w_start;
    logic        w_timeout;
    logic [31:0] w_ext;
    logic [31:0] w_wdata_rep;

    assign w_access   = MemRead | MemWrite;
    assign w_ld_f3_ok = (Funct3 == F3_B) | (Funct3 == F3_H) | (Funct3 == F3_W) |
                        (Funct3 == F3_BU) | (Funct3 == F3_HU);
    assign w_st_f3_ok = (Funct3 == F3_B) | (Funct3 == F3_H) | (Funct3 == F3_W);
    assign w_misalign = (((Funct3 == F3_H) | (Funct3 == F3_HU)) & ALUResult[0]) |
                        ((Funct3 == F3_W) & (|ALUResult[1:0]));
    assign w_fault_any = (MemRead & MemWrite) |
                         (MemRead  & (!w_ld_f3_ok | w_misalign)) |
                         (MemWrite & (!w_st_f3_ok | w_misalign));
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        case (Funct3)
            F3_B:    w_wdata_rep = {4{WriteData[7:0]}};
            F3_H:    w_wdata_rep = {2{WriteData[15:0]}};
            default: w_wdata_rep = WriteData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        MemFault    = 1'b0;
        Stall       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                MemFault = w_fault_any;
                if (w_access && !w_fault_any) begin
                    w_start     = 1'b1;
                    Stall       = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (BusReady || w_timeout) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    load_extend u_load_extend (
        .i_word   (BusRData),
        .i_offset (r_off),
        .i_funct3 (r_f3),
        .o_result (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            BusValid <= 1'b0;
            BusWrite <= 1'b0;
            BusAddr  <= 32'd0;
            BusWData <= 32'd0;
            BusWStrb <= 4'd0;
            ReadData <= 32'd0;
            Done     <= 1'b0;
            BusError <= 1'b0;
            r_cnt    <= '0;
            r_f3     <= 3'd0;
            r_off    <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        BusValid <= 1'b1;
                        BusWrite <= MemWrite;
                        BusAddr  <= {ALUResult[31:2], 2'b00};
                        BusWData <= w_wdata_rep;
                        BusWStrb <= MemWrite ? store_strobe(Funct3, ALUResult[1:0]) : 4'b0000;
                        r_f3     <= Funct3;
                        r_off    <= ALUResult[1:0];
                        r_cnt    <= '0;
                    end
                end
                REQ: begin
                    // Bus outputs stay frozen until the slave answers or we give up.
                    if (BusReady) begin
                        BusValid <= 1'b0;
                        Done     <= 1'b1;
                        ReadData <= BusWrite ? 32'd0 : w_ext;
                    end else if (w_timeout) begin
                        BusValid <= 1'b0;
                        Done     <= 1'b1;
                        BusError <= 1'b1;
                        ReadData <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    Done     <= 1'b0;
                    BusError <= 1'b0;
                    BusWrite <= 1'b0;
                    BusWStrb <= 4'd0;
                end
            endcase
        end
    end

endmodule
